// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer for the single data-memory port.
// Requester 0 is the load/store unit, requester 1 the debug/DMA master. One access
// runs at a time through IDLE -> BUSY -> DONE. A memory that never acks is
// abandoned after TIMEOUT_CYCLES BUSY cycles and the requester receives ack + err.
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_wr_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_wr_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  dmem_req_o,
  output logic                  dmem_wr_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic                  busy_o
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic             win;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Pick the winner for this cycle and decode whether this BUSY cycle is the last allowed one.
  always_comb begin
    win = 1'b0;
    if (m0_req_i && m1_req_i) win = ~last_grant_q;
    else                      win = m1_req_i;
    cnt_inc = sat_inc(cnt_q);
    expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);
  end

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      busy_o       <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_wr_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      m0_ack_o     <= 1'b0;
      m0_err_o     <= 1'b0;
      m0_rdata_o   <= '0;
      m1_ack_o     <= 1'b0;
      m1_err_o     <= 1'b0;
      m1_rdata_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state_q      <= BUSY;
            busy_o       <= 1'b1;
            grant_q      <= win;
            last_grant_q <= win;
            cnt_q        <= '0;
            dmem_req_o   <= 1'b1;
            dmem_wr_o    <= win ? m1_wr_i    : m0_wr_i;
            dmem_addr_o  <= win ? m1_addr_i  : m0_addr_i;
            dmem_wdata_o <= win ? m1_wdata_i : m0_wdata_i;
          end
        end
        BUSY: begin
          cnt_q <= cnt_inc;
          if (dmem_ack_i) begin
            // A real ack beats a timeout that expires in the same cycle.
            state_q    <= DONE;
            dmem_req_o <= 1'b0;
            if (grant_q) begin
              m1_ack_o <= 1'b1;
              if (!dmem_wr_o) m1_rdata_o <= dmem_rdata_i;
            end else begin
              m0_ack_o <= 1'b1;
              if (!dmem_wr_o) m0_rdata_o <= dmem_rdata_i;
            end
          end else if (expire) begin
            state_q    <= DONE;
            dmem_req_o <= 1'b0;
            if (grant_q) begin
              m1_ack_o   <= 1'b1;
              m1_err_o   <= 1'b1;
              m1_rdata_o <= '0;
            end else begin
              m0_ack_o   <= 1'b1;
              m0_err_o   <= 1'b1;
              m0_rdata_o <= '0;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          busy_o       <= 1'b0;
          cnt_q        <= '0;
          dmem_wr_o    <= 1'b0;
          dmem_addr_o  <= '0;
          dmem_wdata_o <= '0;
          m0_ack_o     <= 1'b0;
          m0_err_o     <= 1'b0;
          m1_ack_o     <= 1'b0;
          m1_err_o     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter.
// Instance u_dut uses the default timeout; u_dut_t4 uses TIMEOUT_CYCLES = 4.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          arst_ni;
  logic          m0_req_i, m0_wr_i, m1_req_i, m1_wr_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          dmem_req_o, dmem_wr_o, dmem_ack_i, busy_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o, dmem_rdata_i;

  logic          b_m0_req, b_dmem_ack;
  logic [AW-1:0] b_m0_addr;
  logic [DW-1:0] b_dmem_rdata;
  logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_dmem_req, b_dmem_wr, b_busy;
  logic [AW-1:0] b_dmem_addr;
  logic [DW-1:0] b_dmem_wdata;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) u_dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .m0_req_i(m0_req_i), .m0_wr_i(m0_wr_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_wr_i(m1_wr_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .dmem_req_o(dmem_req_o), .dmem_wr_o(dmem_wr_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .busy_o(busy_o)
  );

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) u_dut_t4 (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .m0_req_i(b_m0_req), .m0_wr_i(1'b0), .m0_addr_i(b_m0_addr), .m0_wdata_i('0),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(1'b0), .m1_wr_i(1'b0), .m1_addr_i('0), .m1_wdata_i('0),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_rdata_o(b_m1_rdata),
    .dmem_req_o(b_dmem_req), .dmem_wr_o(b_dmem_wr), .dmem_addr_o(b_dmem_addr),
    .dmem_wdata_o(b_dmem_wdata), .dmem_rdata_i(b_dmem_rdata), .dmem_ack_i(b_dmem_ack),
    .busy_o(b_busy)
  );

  typedef struct {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  exp_t          sb_b[$];
  int            checks = 0;
  int            errors = 0;
  logic          lg;
  logic [DW-1:0] mrd [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Model of the arbiter: winner from current requests and last grant; memory acks after n_busy BUSY cycles.
  task automatic access(input int n_busy, input logic [DW-1:0] rd, input bit drop);
    exp_t e;
    exp_t got;
    logic w;
    w = (m0_req_i && m1_req_i) ? ~lg : m1_req_i;
    lg = w;
    e.port  = w;
    e.wr    = w ? m1_wr_i    : m0_wr_i;
    e.addr  = w ? m1_addr_i  : m0_addr_i;
    e.wdata = w ? m1_wdata_i : m0_wdata_i;
    e.err   = 1'b0;
    e.rdata = e.wr ? mrd[w] : rd;
    mrd[w]  = e.rdata;
    sb.push_back(e);
    check("dreq_before_edge", dmem_req_o, 1'b0);
    tick();
    check("busy_rise", busy_o, 1'b1);
    for (int c = 1; c <= n_busy; c++) begin
      check("dreq_hold", dmem_req_o, 1'b1);
      check("dmem_wr", dmem_wr_o, e.wr);
      check("dmem_addr", dmem_addr_o, e.addr);
      check("dmem_wdata", dmem_wdata_o, e.wdata);
      check("no_early_ack", {m1_ack_o, m0_ack_o}, 2'b00);
      if (c == n_busy) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rd;
      end
      tick();
      dmem_ack_i = 1'b0;
    end
    dmem_rdata_i = 32'hDEAD_BEEF;
    if (drop) begin
      m0_req_i = 1'b0;
      m1_req_i = 1'b0;
    end
    got = sb.pop_front();
    check("ack_vec", {m1_ack_o, m0_ack_o}, got.port ? 2'b10 : 2'b01);
    check("err_vec", {m1_err_o, m0_err_o}, 2'b00);
    check("rdata_win", got.port ? m1_rdata_o : m0_rdata_o, got.rdata);
    check("rdata_lose", got.port ? m0_rdata_o : m1_rdata_o, mrd[~got.port]);
    check("dreq_fall", dmem_req_o, 1'b0);
    check("busy_done", busy_o, 1'b1);
    tick();
    check("ack_clear", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'b0000);
    check("busy_idle", busy_o, 1'b0);
    check("addr_clear", {dmem_wr_o, dmem_addr_o}, 33'd0);
  endtask

  // Four BUSY cycles on the timeout-4 instance; optional ack in the fourth.
  task automatic b_access(input bit give_ack, input logic [DW-1:0] rd);
    exp_t e;
    exp_t got;
    e.port  = 1'b0;
    e.wr    = 1'b0;
    e.addr  = b_m0_addr;
    e.wdata = '0;
    e.err   = ~give_ack;
    e.rdata = give_ack ? rd : '0;
    sb_b.push_back(e);
    b_m0_req = 1'b1;
    tick();
    check("t4_dreq_rise", b_dmem_req, 1'b1);
    check("t4_addr", b_dmem_addr, e.addr);
    for (int c = 1; c <= 4; c++) begin
      check("t4_busy_hold", {b_busy, b_dmem_req}, 2'b11);
      check("t4_no_early_ack", {b_m0_ack, b_m0_err}, 2'b00);
      if (c == 4 && give_ack) begin
        b_dmem_ack   = 1'b1;
        b_dmem_rdata = rd;
      end
      tick();
      b_dmem_ack = 1'b0;
    end
    b_m0_req = 1'b0;
    got = sb_b.pop_front();
    check("t4_ack", b_m0_ack, 1'b1);
    check("t4_err", b_m0_err, got.err);
    check("t4_rdata", b_m0_rdata, got.rdata);
    check("t4_dreq_fall", b_dmem_req, 1'b0);
    check("t4_m1_quiet", {b_m1_ack, b_m1_err}, 2'b00);
    tick();
    check("t4_ack_clear", {b_m0_ack, b_m0_err}, 2'b00);
    check("t4_busy_idle", b_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_ni = 1'b0;
    m0_req_i = 1'b0; m0_wr_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_wr_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    b_m0_req = 1'b0; b_m0_addr = '0; b_dmem_ack = 1'b0; b_dmem_rdata = '0;
    lg = 1'b1; mrd[0] = '0; mrd[1] = '0;
    tick();
    tick();
    check("rst_ctrl", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, dmem_req_o, dmem_wr_o, busy_o}, 7'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_wdata", dmem_wdata_o, 32'd0);
    check("rst_rdata", {m0_rdata_o, m1_rdata_o}, 64'd0);
    check("rst_t4", {b_busy, b_dmem_req, b_m0_ack, b_dmem_addr}, 35'd0);
    arst_ni = 1'b1;
    tick();

    // Ack while idle must be ignored.
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h99;
    tick();
    dmem_ack_i = 1'b0;
    check("idle_ack_ignored", {m1_ack_o, m0_ack_o, busy_o, dmem_req_o}, 4'b0000);
    check("idle_rdata_kept", m0_rdata_o, 32'd0);

    // m0 read 0x10, acked in the second BUSY cycle with 0xA5.
    m0_wr_i = 1'b0; m0_addr_i = 32'h10; m0_req_i = 1'b1;
    access(2, 32'hA5, 1'b1);

    // Fresh reset, then both requesters hold requests for four accesses.
    arst_ni = 1'b0; #1; arst_ni = 1'b1;
    lg = 1'b1; mrd[0] = '0; mrd[1] = '0;
    tick();
    m0_addr_i = 32'h100; m1_addr_i = 32'h200; m0_req_i = 1'b1; m1_req_i = 1'b1;
    access(1, 32'h11, 1'b0);
    access(1, 32'h22, 1'b0);
    access(1, 32'h33, 1'b0);
    access(1, 32'h44, 1'b1);

    // m1 write 0x5A to 0x20 with a 5-cycle ack delay.
    m1_wr_i = 1'b1; m1_addr_i = 32'h20; m1_wdata_i = 32'h5A; m1_req_i = 1'b1;
    access(5, 32'h77, 1'b1);
    m1_wr_i = 1'b0;

    // Reset in the middle of a BUSY access.
    m0_addr_i = 32'h30; m0_req_i = 1'b1;
    tick();
    check("pre_rst_busy", {busy_o, dmem_req_o}, 2'b11);
    arst_ni = 1'b0;
    #1;
    check("midrst_ctrl", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, dmem_req_o, dmem_wr_o, busy_o}, 7'd0);
    check("midrst_addr", dmem_addr_o, 32'd0);
    check("midrst_rdata", {m0_rdata_o, m1_rdata_o}, 64'd0);
    lg = 1'b1; mrd[0] = '0; mrd[1] = '0;
    m0_req_i = 1'b0;
    tick();
    arst_ni = 1'b1;
    tick();
    check("post_rst_no_ack", {m1_ack_o, m0_ack_o, busy_o}, 3'b000);
    m0_addr_i = 32'h31; m1_addr_i = 32'h32; m0_req_i = 1'b1; m1_req_i = 1'b1;
    access(1, 32'h55, 1'b1);
    m1_req_i = 1'b1;
    access(3, 32'h66, 1'b1);

    // Timeout-4 instance: ack in the fourth BUSY cycle, then no ack at all.
    b_m0_addr = 32'h40;
    b_access(1'b1, 32'h3C);
    b_m0_addr = 32'h44;
    b_access(1'b0, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
